gpio_apb_bank: RTL and testbench



---
 rtl/gpio_bank_pkg.sv | 22 ++
 rtl/gpio_sync_edge.sv | 41 ++++
 rtl/gpio_apb_bank.sv | 187 ++++++++++++++++++
 tb/tb_gpio_apb_bank.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_bank_pkg.sv
// Shared definitions for the GPIO APB bank: register slot addresses, APB FSM states and
// the wait-state counter width.
package gpio_bank_pkg;

    localparam logic [2:0] REG_DIR      = 3'd0;
    localparam logic [2:0] REG_OUT      = 3'd1;
    localparam logic [2:0] REG_IN       = 3'd2;
    localparam logic [2:0] REG_IRQ_EN   = 3'd3;
    localparam logic [2:0] REG_IRQ_STAT = 3'd4;
    localparam logic [2:0] REG_OUT_SET  = 3'd5;
    localparam logic [2:0] REG_OUT_CLR  = 3'd6;
    localparam logic [2:0] REG_ID       = 3'd7;

    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } apb_state_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop synchroniser for the pad inputs plus a rising-edge detector.
// The third (edge) flop exists only when GPIO_BANK_IRQ_EN is defined; otherwise rise is 0.
module gpio_sync_edge #(
    parameter int unsigned Width = 8
) (
    input  logic             sclk,
    input  logic             resetn,
    input  logic [Width-1:0] din_i,
    output logic [Width-1:0] sync_q,
    output logic [Width-1:0] rise
);

    logic [Width-1:0] meta_q;

    always_ff @(posedge sclk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
        end
    end

`ifdef GPIO_BANK_IRQ_EN
    logic [Width-1:0] prev_q;

    always_ff @(posedge sclk or negedge resetn) begin
        if (!resetn) begin
            prev_q <= '0;
        end else begin
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
`else
    assign rise = '0;
`endif

endmodule

// File: rtl/gpio_apb_bank.sv
// APB completer for one GPIO bank: direction/output registers, synced inputs, ID.
// Interrupt registers, edge capture and irq are built only with GPIO_BANK_IRQ_EN defined.
module gpio_apb_bank
    import gpio_bank_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           ADDR_WIDTH  = 3,
    parameter int unsigned           WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = DATA_WIDTH'(8'hA5)
) (
    input  logic                  sclk,
    input  logic                  resetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio_out,
    output logic [DATA_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    // Counter reaching zero marks the last wait cycle, so load one less than the wait count.
    localparam logic [WAIT_CNT_W-1:0] WaitLoad =
        (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

    apb_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  pready_q, pready_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] dir_q, dir_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [DATA_WIDTH-1:0] in_sync, rise, rdata, ien_rd, stat_rd;
    logic [2:0]            reg_sel;
    logic                  access, commit, wr_en, rd_en;

    assign access  = psel & penable;
    assign reg_sel = paddr[2:0];
    assign wr_en   = commit & pwrite;
    assign rd_en   = commit & ~pwrite;

    gpio_sync_edge #(
        .Width (DATA_WIDTH)
    ) u_sync_edge (
        .sclk   (sclk),
        .resetn (resetn),
        .din_i  (gpio_in),
        .sync_q (in_sync),
        .rise   (rise)
    );

    // DONE absorbs the remainder of a held access so each transfer commits once.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pready_d = pready_q;
        commit   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (access) begin
                    if (WAIT_STATES == 0) begin
                        commit  = 1'b1;
                        state_d = StDone;
                    end else begin
                        cnt_d    = WaitLoad;
                        pready_d = 1'b0;
                        state_d  = StWait;
                    end
                end
            end
            StWait: begin
                if (!access) begin
                    pready_d = 1'b1;
                    state_d  = StIdle;
                end else if (cnt_q == '0) begin
                    commit   = 1'b1;
                    pready_d = 1'b1;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (!access) begin
                    state_d = StIdle;
                end
            end
            default: begin
                pready_d = 1'b1;
                state_d  = StIdle;
            end
        endcase
    end

    always_comb begin
        dir_d = dir_q;
        out_d = out_q;
        if (wr_en) begin
            unique case (reg_sel)
                REG_DIR:     dir_d = pwdata;
                REG_OUT:     out_d = pwdata;
                REG_OUT_SET: out_d = out_q | pwdata;
                REG_OUT_CLR: out_d = out_q & ~pwdata;
                default:     ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            REG_DIR:      rdata = dir_q;
            REG_OUT:      rdata = out_q;
            REG_IN:       rdata = in_sync;
            REG_IRQ_EN:   rdata = ien_rd;
            REG_IRQ_STAT: rdata = stat_rd;
            REG_ID:       rdata = ID_VALUE;
            default:      rdata = '0;
        endcase
    end

    assign prdata_d = rd_en ? rdata : prdata_q;

    always_ff @(posedge sclk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            pready_q <= 1'b1;
            prdata_q <= '0;
            dir_q    <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pready_q <= pready_d;
            prdata_q <= prdata_d;
            dir_q    <= dir_d;
            out_q    <= out_d;
        end
    end

`ifdef GPIO_BANK_IRQ_EN
    logic [DATA_WIDTH-1:0] ien_q, ien_d, stat_q, stat_d;

    always_comb begin
        ien_d  = ien_q;
        stat_d = stat_q | rise;
        if (wr_en && reg_sel == REG_IRQ_EN) begin
            ien_d = pwdata;
        end
        // A rise landing in the same cycle as a clear keeps the bit set.
        if (wr_en && reg_sel == REG_IRQ_STAT) begin
            stat_d = (stat_q & ~pwdata) | rise;
        end
    end

    always_ff @(posedge sclk or negedge resetn) begin
        if (!resetn) begin
            ien_q  <= '0;
            stat_q <= '0;
        end else begin
            ien_q  <= ien_d;
            stat_q <= stat_d;
        end
    end

    assign ien_rd  = ien_q;
    assign stat_rd = stat_q;
    assign irq     = |(stat_q & ien_q);
`else
    logic [DATA_WIDTH-1:0] unused_rise;

    assign unused_rise = rise;
    assign ien_rd      = '0;
    assign stat_rd     = '0;
    assign irq         = 1'b0;
`endif

    assign prdata   = prdata_q;
    assign pready   = pready_q;
    assign gpio_oe  = dir_q;
    assign gpio_out = out_q;

endmodule

// File: tb/tb_gpio_apb_bank.sv
// Bench for gpio_apb_bank: a zero-wait bank and a three-wait bank checked every cycle
// against a register-level model, plus directed literal expectations.
module tb_gpio_apb_bank;

`ifdef GPIO_BANK_IRQ_EN
    localparam bit IrqOn = 1'b1;
`else
    localparam bit IrqOn = 1'b0;
`endif
    localparam int Ws0 = 0;
    localparam int Ws1 = 3;

    logic       sclk   = 1'b0;
    logic       resetn = 1'b1;
    logic       psel    [2];
    logic       penable [2];
    logic       pwrite  [2];
    logic [2:0] paddr   [2];
    logic [7:0] pwdata  [2];
    logic [7:0] prdata  [2];
    logic       pready  [2];
    logic [7:0] gpio_out[2];
    logic [7:0] gpio_oe [2];
    logic       irq     [2];
    logic [7:0] gpio_in;

    int checks   = 0;
    int failures = 0;

    always #5 sclk = ~sclk;

    gpio_apb_bank #(.WAIT_STATES(Ws0)) u_dut0 (
        .sclk(sclk), .resetn(resetn), .psel(psel[0]), .penable(penable[0]),
        .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .prdata(prdata[0]),
        .pready(pready[0]), .gpio_in(gpio_in), .gpio_out(gpio_out[0]),
        .gpio_oe(gpio_oe[0]), .irq(irq[0])
    );

    gpio_apb_bank #(.WAIT_STATES(Ws1)) u_dut1 (
        .sclk(sclk), .resetn(resetn), .psel(psel[1]), .penable(penable[1]),
        .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .prdata(prdata[1]),
        .pready(pready[1]), .gpio_in(gpio_in), .gpio_out(gpio_out[1]),
        .gpio_oe(gpio_oe[1]), .irq(irq[1])
    );

    // Register-level model: a transfer commits on its (ws+1)-th consecutive access edge;
    // the synced input seen at an edge is the pad value sampled two edges earlier.
    int         ws     [2] = '{Ws0, Ws1};
    int         m_cnt  [2];
    logic [7:0] m_dir  [2];
    logic [7:0] m_out  [2];
    logic [7:0] m_ien  [2];
    logic [7:0] m_stat [2];
    logic [7:0] m_prd  [2];
    logic [7:0] hist   [3];

    function automatic logic m_pready(input int d);
        return !(m_cnt[d] >= 1 && m_cnt[d] <= ws[d]);
    endfunction

    function automatic logic m_irq(input int d);
        return IrqOn && ((m_stat[d] & m_ien[d]) != 8'h00);
    endfunction

    task automatic check(input string name, input int d, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %02h expected %02h at %0t", name, d, act, exp,
                     $time);
        end
    endtask

    initial begin : model
        logic [7:0] rise;
        logic [7:0] sync2;
        logic [7:0] w1c;
        logic [7:0] rv;
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0; m_dir[d] = 0; m_out[d] = 0; m_ien[d] = 0; m_stat[d] = 0; m_prd[d] = 0;
        end
        for (int i = 0; i < 3; i++) hist[i] = 8'h00;
        forever begin
            @(posedge sclk or negedge resetn);
            if (!resetn) begin
                for (int d = 0; d < 2; d++) begin
                    m_cnt[d] = 0; m_dir[d] = 0; m_out[d] = 0;
                    m_ien[d] = 0; m_stat[d] = 0; m_prd[d] = 0;
                end
                for (int i = 0; i < 3; i++) hist[i] = 8'h00;
            end else begin
                sync2 = hist[1];
                rise  = hist[1] & ~hist[2];
                for (int d = 0; d < 2; d++) begin
                    w1c = 8'h00;
                    if (psel[d] && penable[d]) m_cnt[d]++;
                    else m_cnt[d] = 0;
                    if (m_cnt[d] == ws[d] + 1) begin
                        if (pwrite[d]) begin
                            case (paddr[d])
                                3'd0: m_dir[d] = pwdata[d];
                                3'd1: m_out[d] = pwdata[d];
                                3'd3: if (IrqOn) m_ien[d] = pwdata[d];
                                3'd4: w1c = pwdata[d];
                                3'd5: m_out[d] = m_out[d] | pwdata[d];
                                3'd6: m_out[d] = m_out[d] & ~pwdata[d];
                                default: ;
                            endcase
                        end else begin
                            case (paddr[d])
                                3'd0: rv = m_dir[d];
                                3'd1: rv = m_out[d];
                                3'd2: rv = sync2;
                                3'd3: rv = m_ien[d];
                                3'd4: rv = m_stat[d];
                                3'd7: rv = 8'hA5;
                                default: rv = 8'h00;
                            endcase
                            m_prd[d] = rv;
                        end
                    end
                    if (IrqOn) m_stat[d] = (m_stat[d] & ~w1c) | rise;
                end
                hist[2] = hist[1];
                hist[1] = hist[0];
                hist[0] = gpio_in;
            end
        end
    end

    initial begin : cmp
        forever begin
            @(negedge sclk);
            for (int d = 0; d < 2; d++) begin
                check("pready", d, 8'(pready[d]), 8'(m_pready(d)));
                check("prdata", d, prdata[d], m_prd[d]);
                check("gpio_oe", d, gpio_oe[d], m_dir[d]);
                check("gpio_out", d, gpio_out[d], m_out[d]);
                check("irq", d, 8'(irq[d]), 8'(m_irq(d)));
            end
        end
    end

    // Called at a negedge; holds the access `hold` extra cycles after pready, then idles one.
    task automatic apb(input int d, input logic wr, input logic [2:0] a, input logic [7:0] v,
                       input int hold, output logic [7:0] rd, output int low);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = v;
        @(negedge sclk);
        penable[d] = 1'b1;
        low = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sclk);
            if (pready[d]) break;
            low++;
        end
        check("pready_timeout", d, 8'(pready[d]), 8'h01);
        rd = prdata[d];
        repeat (hold) @(negedge sclk);
        psel[d] = 1'b0; penable[d] = 1'b0;
        @(negedge sclk);
    endtask

    task automatic wr(input int d, input logic [2:0] a, input logic [7:0] v);
        logic [7:0] rd;
        int         low;
        apb(d, 1'b1, a, v, 1, rd, low);
    endtask

    task automatic rd_chk(input string name, input int d, input logic [2:0] a,
                          input logic [7:0] exp);
        logic [7:0] rd;
        int         low;
        apb(d, 1'b0, a, 8'h00, 1, rd, low);
        check(name, d, rd, exp);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0] rdv;
        int         low;
        for (int d = 0; d < 2; d++) begin
            psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = 0; pwdata[d] = 0;
        end
        gpio_in = 8'h00;
        #1 resetn = 1'b0;
        repeat (2) @(negedge sclk);
        for (int d = 0; d < 2; d++) begin
            check("rst_pready", d, 8'(pready[d]), 8'h01);
            check("rst_prdata", d, prdata[d], 8'h00);
            check("rst_oe", d, gpio_oe[d], 8'h00);
            check("rst_out", d, gpio_out[d], 8'h00);
            check("rst_irq", d, 8'(irq[d]), 8'h00);
        end
        resetn = 1'b1;
        @(negedge sclk);

        // Three wait states with the bus held for about ten cycles.
        apb(1, 1'b1, 3'd0, 8'h5A, 5, rdv, low);
        check("wait_low_cycles", 1, 8'(low), 8'd3);
        check("ws3_dir", 1, gpio_oe[1], 8'h5A);

        // Bridge abort while waiting.
        psel[1] = 1; penable[1] = 0; pwrite[1] = 1; paddr[1] = 3'd1; pwdata[1] = 8'hAA;
        @(negedge sclk);
        penable[1] = 1;
        repeat (2) @(negedge sclk);
        psel[1] = 0; penable[1] = 0;
        @(negedge sclk);
        check("abort_out", 1, gpio_out[1], 8'h00);
        check("abort_dir", 1, gpio_oe[1], 8'h5A);

        // Reset asserted while in the wait phase.
        psel[1] = 1; penable[1] = 0; pwrite[1] = 1; paddr[1] = 3'd1; pwdata[1] = 8'h77;
        @(negedge sclk);
        penable[1] = 1;
        @(negedge sclk);
        check("mid_wait_pready", 1, 8'(pready[1]), 8'h00);
        #2 resetn = 1'b0;
        #1;
        check("rst_wait_pready", 1, 8'(pready[1]), 8'h01);
        check("rst_wait_prdata", 1, prdata[1], 8'h00);
        check("rst_wait_dir", 1, gpio_oe[1], 8'h00);
        psel[1] = 0; penable[1] = 0;
        @(negedge sclk);
        resetn = 1'b1;
        @(negedge sclk);
        check("rst_wait_out", 1, gpio_out[1], 8'h00);

        // Zero-wait register access.
        wr(0, 3'd0, 8'hF0);
        wr(0, 3'd1, 8'h3C);
        check("dir_f0", 0, gpio_oe[0], 8'hF0);
        check("out_3c", 0, gpio_out[0], 8'h3C);
        rd_chk("id", 0, 3'd7, 8'hA5);
        rd_chk("rd_dir", 0, 3'd0, 8'hF0);

        wr(0, 3'd1, 8'h0F);
        wr(0, 3'd5, 8'hF0);
        wr(0, 3'd6, 8'h03);
        check("set_clr_out", 0, gpio_out[0], 8'hFC);
        check("set_clr_dir", 0, gpio_oe[0], 8'hF0);
        rd_chk("rd_set_slot", 0, 3'd5, 8'h00);
        rd_chk("rd_clr_slot", 0, 3'd6, 8'h00);
        wr(0, 3'd7, 8'h12);
        rd_chk("id_ro", 0, 3'd7, 8'hA5);

        // Input sync, edge capture and interrupt.
        wr(0, 3'd3, 8'h01);
        gpio_in = 8'h81;
        rd_chk("in_early", 0, 3'd2, 8'h00);
        repeat (3) @(negedge sclk);
        rd_chk("in_synced", 0, 3'd2, 8'h81);
        rd_chk("irq_en", 0, 3'd3, IrqOn ? 8'h01 : 8'h00);
        rd_chk("stat_81", 0, 3'd4, IrqOn ? 8'h81 : 8'h00);
        check("irq_set", 0, 8'(irq[0]), IrqOn ? 8'h01 : 8'h00);
        wr(0, 3'd4, 8'h01);
        rd_chk("stat_w1c", 0, 3'd4, IrqOn ? 8'h80 : 8'h00);
        check("irq_clr", 0, 8'(irq[0]), 8'h00);

        // Rising edge on bit 0 lands on the same edge as its clear.
        gpio_in = 8'h80;
        repeat (4) @(negedge sclk);
        gpio_in = 8'h81;
        @(negedge sclk);
        wr(0, 3'd4, 8'h01);
        rd_chk("stat_set_wins", 0, 3'd4, IrqOn ? 8'h81 : 8'h00);
        check("irq_set_wins", 0, 8'(irq[0]), IrqOn ? 8'h01 : 8'h00);

        repeat (3) @(negedge sclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
